// File: rtl/watch_pkg.sv
// Shared types and constants for the wristwatch time controller.
// Mode encoding, field widths/limits and the wrap-around increment helpers.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_HR  = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max_v);
    return (v >= max_v) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// press pulse on the registered rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Edge detected against the delayed copy so the pulse trails the level by one cycle.
    press_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/watch_time_ctrl.sv
// Wristwatch time registers with RUN / SET_MIN / SET_HR mode FSM and set-mode timeout.
// Optional inc auto-repeat in set modes is enabled by defining WATCH_AUTOREPEAT_EN.
module watch_time_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SET_TIMEOUT     = 30,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int TMO_W = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SET_TIMEOUT - 1);

  mode_e            mode_q, mode_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0]  hr_q, hr_d;
  logic             blink_q, blink_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic mode_level, mode_press;
  logic inc_level, inc_press;
  logic inc_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  always_comb begin
    mode_d  = mode_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    blink_d = blink_q;
    tmo_d   = tmo_q;
    case (mode_q)
      MODE_RUN: begin
        blink_d = 1'b0;
        tmo_d   = '0;
        if (tick_1hz) begin
          sec_d = inc_wrap6(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = inc_wrap6(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hr_d = inc_wrap5(hr_q, HR_MAX);
            end
          end
        end
        // A coincident tick keeps its min/hr carries; only sec is overridden.
        if (mode_press) begin
          mode_d = MODE_SET_MIN;
          sec_d  = '0;
        end
      end
      MODE_SET_MIN, MODE_SET_HR: begin
        sec_d = '0;
        if (mode_press) begin
          mode_d  = (mode_q == MODE_SET_MIN) ? MODE_SET_HR : MODE_RUN;
          blink_d = 1'b0;
          tmo_d   = '0;
        end else begin
          if (tick_1hz) begin
            blink_d = ~blink_q;
            tmo_d   = tmo_q + TMO_W'(1);
          end
          if (inc_evt) begin
            if (mode_q == MODE_SET_MIN) begin
              min_d = inc_wrap6(min_q, MIN_MAX);
            end else begin
              hr_d = inc_wrap5(hr_q, HR_MAX);
            end
            tmo_d = '0;
          end else if (tick_1hz && (tmo_q == TMO_LAST)) begin
            mode_d  = MODE_RUN;
            blink_d = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      default: begin
        mode_d  = MODE_RUN;
        blink_d = 1'b0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      blink_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      blink_q <= blink_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef WATCH_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_fire;
  logic             in_set;

  assign in_set   = (mode_q == MODE_SET_MIN) || (mode_q == MODE_SET_HR);
  // Counter value 0 means idle; a press loads 1 so the count equals cycles since the pulse.
  assign rpt_fire = in_set && inc_level && (rpt_cnt_q != '0) &&
                    (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_V : RPT_RATE_V));
  assign inc_evt  = inc_press | rpt_fire;

  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = rpt_first_q;
    if (!in_set || !inc_level || (mode_d != mode_q)) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (inc_press) begin
      rpt_cnt_d   = RPT_W'(1);
      rpt_first_d = 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt_d   = RPT_W'(1);
      rpt_first_d = 1'b0;
    end else if (rpt_cnt_q != '0) begin
      rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = inc_level & (REPEAT_DELAY > 0) & (REPEAT_RATE > 0);
  assign inc_evt       = inc_press;
`endif

  logic unused_mode_level;
  assign unused_mode_level = mode_level;

  assign sec   = sec_q;
  assign min   = min_q;
  assign hr    = hr_q;
  assign mode  = mode_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Directed bench for watch_time_ctrl: vector table plus hand sequences for rollover,
// bounce, wrap, timeout, conflicts, reset and the optional auto-repeat.
module tb_watch_time_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [1:0] mode;
  logic       blink;

  int checks = 0;
  int errors = 0;

`ifdef WATCH_AUTOREPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  watch_time_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SET_TIMEOUT     (3),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_TICK, OP_MODE, OP_INC} op_e;
  typedef struct {
    op_e op;
    int  es;
    int  em;
    int  eh;
    int  emd;
    int  eb;
  } vec_t;

  vec_t vecs[20];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int es, input int em, input int eh,
                       input int emd, input int eb);
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [1:0] md;
    logic       b;
    s = es[5:0]; m = em[5:0]; h = eh[4:0]; md = emd[1:0]; b = eb[0];
    checks++;
    if ({sec, min, hr, mode, blink} !== {s, m, h, md, b}) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d",
               name, hr, min, sec, mode, blink, eh, em, es, emd, eb);
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(1);
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) btn_mode = 1'b1;
    else         btn_inc  = 1'b1;
    step(8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(8);
  endtask

  initial begin
    vecs[0]  = '{OP_TICK, 1, 0, 0, 0, 0};
    vecs[1]  = '{OP_TICK, 2, 0, 0, 0, 0};
    vecs[2]  = '{OP_MODE, 0, 0, 0, 1, 0};
    vecs[3]  = '{OP_INC,  0, 1, 0, 1, 0};
    vecs[4]  = '{OP_TICK, 0, 1, 0, 1, 1};
    vecs[5]  = '{OP_INC,  0, 2, 0, 1, 1};
    vecs[6]  = '{OP_TICK, 0, 2, 0, 1, 0};
    vecs[7]  = '{OP_TICK, 0, 2, 0, 1, 1};
    vecs[8]  = '{OP_INC,  0, 3, 0, 1, 1};
    vecs[9]  = '{OP_MODE, 0, 3, 0, 2, 0};
    vecs[10] = '{OP_INC,  0, 3, 1, 2, 0};
    vecs[11] = '{OP_TICK, 0, 3, 1, 2, 1};
    vecs[12] = '{OP_TICK, 0, 3, 1, 2, 0};
    vecs[13] = '{OP_TICK, 0, 3, 1, 0, 0};
    vecs[14] = '{OP_TICK, 1, 3, 1, 0, 0};
    vecs[15] = '{OP_INC,  1, 3, 1, 0, 0};
    vecs[16] = '{OP_TICK, 2, 3, 1, 0, 0};
    vecs[17] = '{OP_MODE, 0, 3, 1, 1, 0};
    vecs[18] = '{OP_MODE, 0, 3, 1, 2, 0};
    vecs[19] = '{OP_MODE, 0, 3, 1, 0, 0};

    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_state", 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      case (vecs[i].op)
        OP_TICK: do_tick();
        OP_MODE: press(1'b1);
        default: press(1'b0);
      endcase
      check($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].eh, vecs[i].emd, vecs[i].eb);
    end

    // Set wrap and load 23:59:58, then roll over.
    press(1'b1);
    for (int i = 0; i < 56; i++) press(1'b0);
    check("min_to_59", 0, 59, 1, 1, 0);
    press(1'b0);
    check("min_wrap_no_carry", 0, 0, 1, 1, 0);
    for (int i = 0; i < 59; i++) press(1'b0);
    press(1'b1);
    for (int i = 0; i < 22; i++) press(1'b0);
    check("hr_to_23", 0, 59, 23, 2, 0);
    press(1'b0);
    check("hr_wrap", 0, 59, 0, 2, 0);
    for (int i = 0; i < 23; i++) press(1'b0);
    press(1'b1);
    check("back_to_run", 0, 59, 23, 0, 0);
    for (int i = 0; i < 58; i++) do_tick();
    check("sec_58", 58, 59, 23, 0, 0);
    do_tick();
    check("sec_59", 59, 59, 23, 0, 0);
    do_tick();
    check("rollover", 0, 0, 0, 0, 0);

    // Bounce rejection in SET_MIN.
    press(1'b1);
    check("enter_set_min", 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      btn_inc = (((i >> 1) & 1) == 0);
      step(1);
    end
    btn_inc = 1'b1;
    step(7);
    check("bounce_before_pulse", 0, 0, 0, 1, 0);
    step(1);
    check("bounce_single_inc", 0, 1, 0, 1, 0);
    step(4);
    check("bounce_no_double", 0, 1, 0, 1, 0);
    btn_inc = 1'b0;
    step(8);

    // Mode and inc pressed together: mode wins.
    btn_mode = 1'b1; btn_inc = 1'b1;
    step(8);
    check("mode_beats_inc", 0, 1, 0, 2, 0);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(8);
    press(1'b1);
    check("exit_to_run", 0, 1, 0, 0, 0);

    // Tick coincident with mode press in RUN at sec 59.
    for (int i = 0; i < 59; i++) do_tick();
    check("sec59_pre_conflict", 59, 1, 0, 0, 0);
    btn_mode = 1'b1;
    step(7);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    check("tick_mode_conflict", 0, 2, 0, 1, 0);
    btn_mode = 1'b0;
    step(8);

    // Inc coincident with the would-be timeout tick.
    do_tick();
    do_tick();
    btn_inc = 1'b1;
    step(7);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    check("inc_beats_timeout", 0, 3, 0, 1, 1);
    btn_inc = 1'b0;
    step(8);
    do_tick();
    do_tick();
    check("timeout_restarted", 0, 3, 0, 1, 1);
    do_tick();
    check("timeout_exit", 0, 3, 0, 0, 0);

    // Reset in the middle of a set mode.
    press(1'b1);
    do_tick();
    check("pre_reset_set", 0, 3, 0, 1, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_mid_set", 0, 0, 0, 0, 0);

    // Held inc in SET_MIN.
    press(1'b1);
    btn_inc = 1'b1;
    step(8);
    check("hold_first", 0, 1, 0, 1, 0);
    step(19);
    check("hold_before_repeat", 0, 1, 0, 1, 0);
    step(1);
    check("hold_repeat1", 0, REP_ON ? 2 : 1, 0, 1, 0);
    step(8);
    check("hold_repeat2", 0, REP_ON ? 3 : 1, 0, 1, 0);
    step(8);
    check("hold_repeat3", 0, REP_ON ? 4 : 1, 0, 1, 0);
    btn_inc = 1'b0;
    step(20);
    check("release_stops", 0, REP_ON ? 4 : 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
